// File: rtl/csa_mul_pkg.sv
// Shared definitions for the sequential carry-save multiplier.
//   state_e       : controller states
//   clog2         : ceiling log2, used to size the iteration counter
//   op_magnitude  : operand magnitude (two's-complement abs when signed)
//   op_neg_flag   : sign of the final product
package csa_mul_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Upper bound on operand width handled by the helper functions.
  localparam int MAX_OPW      = 128;
  localparam int MAX_OPW_IDXW = 7;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Operand occupies x[w-1:0]. The most negative value maps to 2^(w-1),
  // which still fits as an unsigned w-bit number.
  function automatic logic [MAX_OPW-1:0] op_magnitude(input logic [MAX_OPW-1:0] x,
                                                      input int               w,
                                                      input logic             sgn);
    logic [MAX_OPW-1:0] mask;
    mask = {MAX_OPW{1'b1}} >> (MAX_OPW - w);
    if (sgn && x[MAX_OPW_IDXW'(w - 1)]) return (~x + 1'b1) & mask;
    return x & mask;
  endfunction

  function automatic logic op_neg_flag(input logic sgn, input logic a_msb, input logic b_msb);
    return sgn & (a_msb ^ b_msb);
  endfunction

endpackage

// File: rtl/csa_row.sv
// One 3:2 carry-save compressor row.
//   x_i, y_i, z_i : three W-bit addends
//   sum_o         : bitwise sum without propagation
//   carry_o       : majority bits, already shifted to their weight
// x + y + z == sum_o + carry_o (mod 2^W).
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] z_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  logic [W-1:0] maj;

  assign sum_o   = x_i ^ y_i ^ z_i;
  assign maj     = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);
  assign carry_o = maj << 1;

endmodule

// File: rtl/csa_multiplier_seq.sv
// Iterative carry-save multiplier behind valid/ready handshakes.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only when idle)
//   a, b, is_signed     : operands, sampled only on the accepting edge
//   out_valid/out_ready : product handshake, p held until taken
//   p                   : 2*WIDTH-bit product
//   busy                : high whenever not idle
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// ACCUM   | retiring BITS_PER_CYCLE multiplier bits per cycle into sum/carry
// RESOLVE | sum + carry, apply sign, register p
// DONE    | out_valid high, waiting for out_ready
module csa_multiplier_seq
  import csa_mul_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int ITER  = WIDTH / BITS_PER_CYCLE;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = clog2(ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  if (WIDTH < 4 || (WIDTH % 2) != 0 || WIDTH > MAX_OPW ||
      BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH ||
      (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
    $error("csa_multiplier_seq: WIDTH must be >=4 and even, BITS_PER_CYCLE must divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    sum_q, sum_d;
  logic [PW-1:0]    carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    p_raw;

  logic [PW-1:0] pp        [BITS_PER_CYCLE];
  logic [PW-1:0] row_sum   [BITS_PER_CYCLE];
  logic [PW-1:0] row_carry [BITS_PER_CYCLE];

  assign mag_a = WIDTH'(op_magnitude(MAX_OPW'(a), WIDTH, is_signed));
  assign mag_b = WIDTH'(op_magnitude(MAX_OPW'(b), WIDTH, is_signed));

  // The multiplicand is pre-shifted each cycle, so partial product j only
  // needs its local offset j.
  for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_row
    assign pp[j] = mplier_q[j] ? (mcand_q << j) : '0;
    if (j == 0) begin : g_first
      csa_row #(.W(PW)) u_row (
        .x_i    (sum_q),
        .y_i    (carry_q),
        .z_i    (pp[j]),
        .sum_o  (row_sum[j]),
        .carry_o(row_carry[j])
      );
    end else begin : g_next
      csa_row #(.W(PW)) u_row (
        .x_i    (row_sum[j-1]),
        .y_i    (row_carry[j-1]),
        .z_i    (pp[j]),
        .sum_o  (row_sum[j]),
        .carry_o(row_carry[j])
      );
    end
  end

  assign p_raw = sum_q + carry_q;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = PW'(mag_a);
          mplier_d = mag_b;
          neg_d    = op_neg_flag(is_signed, a[WIDTH-1], b[WIDTH-1]);
          sum_d    = '0;
          carry_d  = '0;
          cnt_d    = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        sum_d    = row_sum[BITS_PER_CYCLE-1];
        carry_d  = row_carry[BITS_PER_CYCLE-1];
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = RESOLVE;
      end
      RESOLVE: begin
        // A zero magnitude negates to zero, so no special case is needed.
        p_d     = neg_q ? (~p_raw + 1'b1) : p_raw;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      sum_q    <= '0;
      carry_q  <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;

endmodule

// File: tb/tb_csa_multiplier_seq.sv
// Self-checking bench for csa_multiplier_seq: a 32-bit default instance for
// directed, table-driven and random tests, plus four 8-bit instances
// (BITS_PER_CYCLE = 1, 2, 4, 8) run in lockstep on shared operands.
// Latency is counted with the accepting edge as edge 1.
module tb_csa_multiplier_seq;

  localparam int W32    = 32;
  localparam int ITER32 = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     a, b;
  logic            is_signed;
  logic            out_valid;
  logic            out_ready;
  logic [63:0]     p;
  logic            busy;

  logic            sw_rst;
  logic            sw_in_valid;
  logic            sw_out_ready;
  logic [7:0]      sw_a, sw_b;
  logic            sw_s;
  logic [3:0]      sw_in_ready, sw_out_valid, sw_busy;
  logic [15:0]     sw_p [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csa_multiplier_seq #(.WIDTH(W32), .BITS_PER_CYCLE(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .is_signed(is_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p),
    .busy     (busy)
  );

  for (genvar k = 0; k < 4; k++) begin : g_sweep
    csa_multiplier_seq #(.WIDTH(8), .BITS_PER_CYCLE(1 << k)) u_dut8 (
      .clk      (clk),
      .rst      (sw_rst),
      .in_valid (sw_in_valid),
      .in_ready (sw_in_ready[k]),
      .a        (sw_a),
      .b        (sw_b),
      .is_signed(sw_s),
      .out_valid(sw_out_valid[k]),
      .out_ready(sw_out_ready),
      .p        (sw_p[k]),
      .busy     (sw_busy[k])
    );
  end

  // Reference products from plain integer arithmetic.
  function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
    int sx, sy;
    if (s) begin
      sx = int'($signed(x));
      sy = int'($signed(y));
      return 16'(sx * sy);
    end
    return {8'd0, x} * {8'd0, y};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one operation on the 32-bit DUT with out_ready held high and
  // check latency, product and the single-cycle out_valid pulse.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_op, input logic ts,
                        input logic [63:0] exp, input string nm);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    a = ta; b = tb_op; is_signed = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    a         = $urandom;
    b         = $urandom;
    is_signed = 1'($urandom_range(1));
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({nm, "_latency"}, 64'(n), 64'(ITER32 + 2));
    check({nm, "_p"}, p, exp);
    @(posedge clk);
    @(negedge clk);
    check({nm, "_valid_pulse"}, 64'(out_valid), 64'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [10];
  logic [7:0] corner [5];

  initial begin
    int n, seen_hi;
    logic [31:0] ra, rb;
    logic        rs;

    vecs[0] = '{32'd3,          32'd5,          1'b0, 64'd15};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd123456,     32'd789012,     1'b0, 64'd97408265472};
    vecs[3] = '{32'hFFFF_FFFD,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[4] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'd1};
    vecs[5] = '{32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000};
    vecs[6] = '{32'd0,          32'hFFFF_FFFB,  1'b1, 64'd0};
    vecs[7] = '{32'h7FFF_FFFF,  32'h8000_0000,  1'b1, 64'hC000_0000_8000_0000};
    vecs[8] = '{32'hFFFF_FFFF,  32'd2,          1'b0, 64'h1_FFFF_FFFE};
    vecs[9] = '{32'h8000_0000,  32'd2,          1'b0, 64'h1_0000_0000};
    corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
    corner[3] = 8'h80; corner[4] = 8'hFF;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; is_signed = 1'b0;
    sw_rst = 1'b1; sw_in_valid = 1'b0; sw_out_ready = 1'b1; sw_a = '0; sw_b = '0; sw_s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy",      64'(busy),      64'd0);
    check("reset_p",         p,              64'd0);
    check("reset_sw_busy",   64'(sw_busy),   64'd0);
    rst = 1'b0; sw_rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(1));
      if (i % 8 == 0) ra = 32'h8000_0000;
      run_op(ra, rb, rs, ref32(ra, rb, rs), $sformatf("rand%0d", i));
    end

    // Backpressure in DONE, then release with new operands already waiting.
    @(negedge clk);
    a = 32'd7; b = 32'd9; is_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("bp_latency", 64'(n), 64'(ITER32 + 2));
    check("bp_p", p, 64'd63);
    a = 32'd11; b = 32'd13; is_signed = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid",    64'(out_valid), 64'd1);
      check("bp_hold_p",        p,              64'd63);
      check("bp_hold_in_ready", 64'(in_ready),  64'd0);
      check("bp_hold_busy",     64'(busy),      64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid",    64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready),  64'd1);
    check("bp_release_busy",     64'(busy),      64'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_pending_accepted", 64'(busy), 64'd1);
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("bp_pending_latency", 64'(n), 64'(ITER32 + 2));
    check("bp_pending_p", p, 64'd143);
    @(posedge clk);
    @(negedge clk);

    // Reset during the 4th ACCUM cycle discards the operation.
    a = 32'd20; b = 32'd30; is_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_busy",      64'(busy),      64'd0);
    check("midrst_p",         p,              64'd0);
    seen_hi = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen_hi++;
    end
    check("midrst_no_output", 64'(seen_hi), 64'd0);
    run_op(32'd7, 32'd6, 1'b0, 64'd42, "after_rst");

    // WIDTH=8 instances in lockstep: all corner pairs, then random pairs.
    for (int t = 0; t < 650; t++) begin
      logic [7:0]  xa, xb;
      logic        xs;
      logic [15:0] exp8;
      logic [3:0]  seen;
      logic [15:0] got [4];
      int          lat [4];
      if (t < 50) begin
        xa = corner[(t / 10) % 5];
        xb = corner[(t / 2) % 5];
        xs = 1'(t % 2);
      end else begin
        xa = 8'($urandom);
        xb = 8'($urandom);
        xs = 1'($urandom_range(1));
      end
      exp8 = ref8(xa, xb, xs);
      @(negedge clk);
      check("sw_in_ready", 64'(sw_in_ready), 64'hF);
      sw_a = xa; sw_b = xb; sw_s = xs; sw_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sw_in_valid = 1'b0;
      sw_a = 8'($urandom);
      sw_b = 8'($urandom);
      sw_s = 1'($urandom_range(1));
      seen = '0;
      for (int k = 0; k < 4; k++) begin
        got[k] = '1;
        lat[k] = 0;
      end
      n = 1;
      while (seen != 4'hF && n < 20) begin
        for (int k = 0; k < 4; k++) begin
          if (sw_out_valid[k] && !seen[k]) begin
            seen[k] = 1'b1;
            lat[k]  = n;
            got[k]  = sw_p[k];
          end
        end
        if (seen != 4'hF) begin
          @(posedge clk);
          n++;
          @(negedge clk);
        end
      end
      for (int k = 0; k < 4; k++) begin
        check($sformatf("sw8_bpc%0d_p(a=%0h b=%0h s=%0d)", 1 << k, xa, xb, xs),
              64'(got[k]), 64'(exp8));
        check($sformatf("sw8_bpc%0d_latency", 1 << k), 64'(lat[k]), 64'(8 / (1 << k) + 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog timeout");
  end

endmodule
